// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_redirect_ctrl: fetch-PC sequencer (boot, irq entry, mret, jump, stall).  |
// | Optional stall counter output enabled by `define PC_CTRL_STALL_CNT_EN.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hzd_stall,
    input  logic        alu_jump_req,
    input  logic [31:0] jump_pc,
    input  logic        irq_req,
    output logic        irq_ack,
    input  logic [31:0] trap_vec,
    input  logic        mret_req,
    input  logic [31:0] mepc,
    input  logic [31:0] cur_pc,
    output logic        epc_we,
    output logic [31:0] epc_out,
    output logic        ctrl_pc_stall,
    output logic [1:0]  ctrl_pc_jump_sel,
    output logic [31:0] ctrl_pc,
    output logic        in_trap
`ifdef PC_CTRL_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned BOOT_LAST = (BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0;
    localparam int unsigned CNT_W     = (BOOT_LAST > 0) ? $clog2(BOOT_LAST + 1) : 1;

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_JUMP = 2'b01;
    localparam logic [1:0] SEL_SEQ  = 2'b10;

    localparam logic KIND_JUMP = 1'b0;
    localparam logic KIND_MRET = 1'b1;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   boot_cnt_q, boot_cnt_d;
    logic               pend_vld_q, pend_vld_d;
    logic               pend_kind_q, pend_kind_d;
    logic [31:0]        pend_pc_q, pend_pc_d;
    logic               in_trap_q, in_trap_d;
    logic               boot_done;
    logic               new_req;
    logic               new_kind;
    logic [31:0]        new_pc;

    assign boot_done = (boot_cnt_q == CNT_W'(BOOT_LAST));

    // mret outranks a jump when both arrive together and one must be kept
    assign new_req  = mret_req | alu_jump_req;
    assign new_kind = mret_req ? KIND_MRET : KIND_JUMP;
    assign new_pc   = mret_req ? mepc : jump_pc;

    always_comb begin
        state_d          = state_q;
        boot_cnt_d       = boot_cnt_q;
        pend_vld_d       = pend_vld_q;
        pend_kind_d      = pend_kind_q;
        pend_pc_d        = pend_pc_q;
        in_trap_d        = in_trap_q;
        ctrl_pc_stall    = 1'b1;
        ctrl_pc_jump_sel = SEL_LOAD;
        ctrl_pc          = RESET_PC;
        irq_ack          = 1'b0;
        epc_we           = 1'b0;
        epc_out          = 32'h0;

        case (state_q)
            ST_BOOT: begin
                if (boot_done) begin
                    ctrl_pc_stall = 1'b0;
                    state_d       = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                ctrl_pc_stall    = 1'b0;
                ctrl_pc_jump_sel = SEL_SEQ;
                if (pend_vld_q && !hzd_stall) begin
                    // replay the deferred redirect; a fresh request becomes the next pending
                    ctrl_pc_jump_sel = SEL_LOAD;
                    ctrl_pc          = pend_pc_q;
                    pend_vld_d       = new_req;
                    if (new_req) begin
                        pend_kind_d = new_kind;
                        pend_pc_d   = new_pc;
                    end
                    if (pend_kind_q == KIND_MRET) begin
                        in_trap_d = 1'b0;
                    end
                end else if (hzd_stall) begin
                    ctrl_pc_stall = 1'b1;
                    if (new_req && (!pend_vld_q || new_kind == KIND_MRET ||
                                    pend_kind_q == KIND_JUMP)) begin
                        pend_vld_d  = 1'b1;
                        pend_kind_d = new_kind;
                        pend_pc_d   = new_pc;
                    end
                end else if (irq_req && !in_trap_q) begin
                    ctrl_pc_jump_sel = SEL_LOAD;
                    ctrl_pc          = trap_vec;
                    irq_ack          = 1'b1;
                    epc_we           = 1'b1;
                    epc_out          = alu_jump_req ? jump_pc : cur_pc;
                    in_trap_d        = 1'b1;
                end else if (mret_req) begin
                    ctrl_pc_jump_sel = SEL_LOAD;
                    ctrl_pc          = mepc;
                    in_trap_d        = 1'b0;
                end else if (alu_jump_req) begin
                    ctrl_pc_jump_sel = SEL_JUMP;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= '0;
            pend_vld_q  <= 1'b0;
            pend_kind_q <= KIND_JUMP;
            pend_pc_q   <= 32'h0;
            in_trap_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_kind_q <= pend_kind_d;
            pend_pc_q   <= pend_pc_d;
            in_trap_q   <= in_trap_d;
        end
    end

    assign in_trap = in_trap_q;

`ifdef PC_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_RUN && ctrl_pc_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
